demux_lane_sequencer: RTL and testbench
=======================================

Name: demux_lane_sequencer

Overview:
- Sequential front end for the 1:4 demux path.
- Accepts a stream of data words over a valid/ready handshake and generates the 2-bit lane select (S1:S0) internally.
- Steers each accepted word into one of four lane registers, lane 0 first, then 1, 2 and 3.
- Presents the four captured lanes as one frame to the downstream partial-product stage of the multiplier datapath.

Parameters:
- WIDTH, 8, bit width of each data word and each lane register.
- LANES, 4, number of output lanes; fixed at 4 and not overridable. It exists only for readability.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the current frame.
- in_data  input  WIDTH  word to be steered.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle. Combinational from state and frame_ready.
- sel  output  2  current lane select, S1=sel[1], S0=sel[0]. Registered.
- lane_strobe  output  4  registered one-hot pulse marking the lane written on the previous edge.
- lane0_data, lane1_data, lane2_data, lane3_data  output  WIDTH each  lane registers.
- frame_valid  output  1  all four lanes hold a complete frame.
- frame_ready  input  1  downstream consumes the frame.

Behaviour:
- Reset (rst_n=0, asynchronous): state=FILL, sel=0, lane_strobe=0, frame_valid=0, all lane registers=0. While in reset, in_ready follows the FILL rule (=1).
- Accept condition: accept = in_valid & in_ready.
- in_ready:
  - FILL: in_ready = 1.
  - HOLD: in_ready = frame_ready. This allows back-to-back frames with no bubble.
- FILL state, on accept:
  - lane[sel] <= in_data.
  - lane_strobe <= one-hot(sel).
  - sel <= sel+1, wrapping modulo 4.
  - If sel==3: go to HOLD and set frame_valid <= 1. The frame is visible the cycle after the 4th word, so latency from 4th accept to frame_valid is 1 cycle.
- FILL state, no accept: all registers hold and lane_strobe <= 0.
- HOLD state:
  - frame_valid=1 and the lanes are stable.
  - No lane register changes unless frame_ready=1.
- HOLD state, frame_ready=1:
  - Frame consumed: frame_valid <= 0, state <= FILL.
  - If an accept also occurs in the same cycle, lane0 <= in_data, lane_strobe <= 0001 and sel <= 1.
  - Lanes 1-3 keep stale data until they are overwritten; this is legal because frame_valid=0.
- frame_valid=1 with frame_ready=0: the block stalls indefinitely; in_ready=0 and no data is lost.
- flush:
  - Highest priority over accept and over frame_ready.
  - Effect on next edge: sel=0, state=FILL, frame_valid=0, lane_strobe=0, all lanes=0.
  - A word presented with in_valid during flush is dropped. in_ready still follows the state rule, so upstream sees it as accepted.
- Reset mid-frame: partial data is discarded; behaviour is identical to power-up reset.
- sel always equals the number of words accepted in the current frame, modulo 4. It is 0 in HOLD.
- lane_strobe has at most one bit set, for exactly one cycle per accepted word.

Decomposition:
- Shared package demux_pkg:
  - State enum {FILL, HOLD}.
  - Constants SEL_W=2 and NUM_LANES=4.
  - One-hot lane constants LANE0_OH through LANE3_OH.
- Sub-module demux_decode_1to4: combinational 2-to-4 one-hot decoder with enable, mirroring the gate-level 1:4 demux.
  - Inputs: sel[1:0], en.
  - Output: oh[3:0].
  - The sequencer instantiates it with en=accept to produce the lane write enables and the strobe next-value.

Test Plan:
- Reset, then 4 consecutive accepts 0x11, 0x22, 0x33, 0x44 with frame_ready=0 -> lane_strobe sequence 0001, 0010, 0100, 1000; sel 0→1→2→3→0; frame_valid=1 one cycle after the 4th accept; lanes = 11/22/33/44; in_ready=0.
- Hold frame_valid for 10 cycles with in_valid=1 and frame_ready=0 -> lanes unchanged, no strobe; then frame_ready=1 with in_data=0x55 -> frame_valid=0, lane0=0x55, sel=1, strobe=0001 on the same edge.
- Gapped input: in_valid toggled 1,0,0,1,1,0,1 with words A0..A3 -> only accepted words are written, in order, to lanes 0-3; frame_valid is asserted exactly once.
- flush after 2 accepts (0x01, 0x02) -> next cycle sel=0, lanes=0, frame_valid=0; then 4 words 0x0A-0x0D -> frame with lanes 0A/0B/0C/0D.
- flush asserted together with frame_ready=1 and in_valid=1 in HOLD -> flush wins: lanes=0, sel=0, no strobe.
- Async reset asserted mid-clock after 3 accepts -> all outputs 0 immediately, without waiting for a clock edge; after release, a fresh 4-word frame is captured correctly starting at lane 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:4 demux lane sequencer.
package demux_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } demux_state_e;

  localparam int SEL_W     = 2;
  localparam int NUM_LANES = 4;

  localparam logic [NUM_LANES-1:0] LANE0_OH = 4'b0001;
  localparam logic [NUM_LANES-1:0] LANE1_OH = 4'b0010;
  localparam logic [NUM_LANES-1:0] LANE2_OH = 4'b0100;
  localparam logic [NUM_LANES-1:0] LANE3_OH = 4'b1000;

endpackage

// File: rtl/demux_decode_1to4.sv
// 2-to-4 one-hot decoder with enable; the gate-level core of the 1:4 demux.
module demux_decode_1to4
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0]     sel,
  input  logic                 en,
  output logic [NUM_LANES-1:0] oh
);

  always_comb begin
    oh = '0;
    if (en) begin
      unique case (sel)
        2'd0: oh = LANE0_OH;
        2'd1: oh = LANE1_OH;
        2'd2: oh = LANE2_OH;
        2'd3: oh = LANE3_OH;
        default: oh = '0;
      endcase
    end
  end

endmodule

// File: rtl/demux_lane_sequencer.sv
// Valid/ready front end that steers successive words into four lane registers
// and presents them as one frame to the partial-product stage.
module demux_lane_sequencer
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [SEL_W-1:0]     sel,
  output logic [NUM_LANES-1:0] lane_strobe,
  output logic [WIDTH-1:0]     lane0_data,
  output logic [WIDTH-1:0]     lane1_data,
  output logic [WIDTH-1:0]     lane2_data,
  output logic [WIDTH-1:0]     lane3_data,
  output logic                 frame_valid,
  input  logic                 frame_ready
);

  localparam int LANES = NUM_LANES;

  demux_state_e           state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [LANES-1:0]       strobe_q, strobe_d;
  logic                   frame_valid_q, frame_valid_d;
  logic [WIDTH-1:0]       lane_q [LANES];
  logic [WIDTH-1:0]       lane_d [LANES];
  logic                   accept;
  logic [LANES-1:0]       lane_we;

  assign in_ready = (state_q == FILL) | frame_ready;
  assign accept   = in_valid & in_ready;

  // sel_q is 0 in HOLD, so a same-cycle accept on frame release lands in lane 0.
  demux_decode_1to4 u_decode (
    .sel (sel_q),
    .en  (accept),
    .oh  (lane_we)
  );

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    strobe_d      = lane_we;
    frame_valid_d = frame_valid_q;
    lane_d        = lane_q;
    if (flush) begin
      state_d       = FILL;
      sel_d         = '0;
      strobe_d      = '0;
      frame_valid_d = 1'b0;
      for (int unsigned i = 0; i < LANES; i++) lane_d[i] = '0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (lane_we[i]) lane_d[i] = in_data;
      end
      if (accept) sel_d = sel_q + 2'd1;
      unique case (state_q)
        FILL: begin
          if (accept && sel_q == SEL_W'(LANES - 1)) begin
            state_d       = HOLD;
            frame_valid_d = 1'b1;
          end
        end
        HOLD: begin
          if (frame_ready) begin
            state_d       = FILL;
            frame_valid_d = 1'b0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      sel_q         <= '0;
      strobe_q      <= '0;
      frame_valid_q <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      strobe_q      <= strobe_d;
      frame_valid_q <= frame_valid_d;
      for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= lane_d[i];
    end
  end

  assign sel         = sel_q;
  assign lane_strobe = strobe_q;
  assign frame_valid = frame_valid_q;
  assign lane0_data  = lane_q[0];
  assign lane1_data  = lane_q[1];
  assign lane2_data  = lane_q[2];
  assign lane3_data  = lane_q[3];

endmodule

// File: tb/tb_demux_lane_sequencer.sv
// Directed bench for demux_lane_sequencer with a scoreboard of expected lane writes.
module tb_demux_lane_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic [3:0] lane_strobe;
  logic [7:0] lane0_data, lane1_data, lane2_data, lane3_data;
  logic       frame_valid;
  logic       frame_ready;

  typedef struct {
    int         lane;
    logic [7:0] data;
  } wr_t;

  wr_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  int  fv_rises = 0;
  logic fv_prev = 1'b0;

  always #5 clk = ~clk;

  demux_lane_sequencer #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sel         (sel),
    .lane_strobe (lane_strobe),
    .lane0_data  (lane0_data),
    .lane1_data  (lane1_data),
    .lane2_data  (lane2_data),
    .lane3_data  (lane3_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lane_of(input int idx);
    case (idx)
      0:       return lane0_data;
      1:       return lane1_data;
      2:       return lane2_data;
      default: return lane3_data;
    endcase
  endfunction

  task automatic push(input int lane, input logic [7:0] data);
    wr_t e;
    e.lane = lane;
    e.data = data;
    sbq.push_back(e);
  endtask

  task automatic monitor();
    wr_t e;
    if (lane_strobe !== 4'b0000) begin
      if (sbq.size() == 0) begin
        chk("unexpected_strobe", 32'(lane_strobe), 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("strobe", 32'(lane_strobe), 32'(4'b0001 << e.lane));
        chk("lane_data", 32'(lane_of(e.lane)), 32'(e.data));
      end
    end
    if (frame_valid === 1'b1 && fv_prev !== 1'b1) fv_rises++;
    fv_prev = frame_valid;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic chk_lanes(input string tag, input logic [31:0] exp);
    chk(tag, {lane3_data, lane2_data, lane1_data, lane0_data}, exp);
  endtask

  logic [7:0] words [4];
  logic       gap_pat [7];

  initial begin
    int w;
    rst_n = 1'b0; flush = 1'b0; in_data = '0; in_valid = 1'b0; frame_ready = 1'b0;
    #12;
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_strobe", 32'(lane_strobe), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk_lanes("rst_lanes", 32'h0);
    rst_n = 1'b1;

    // Four back-to-back accepts with downstream stalled.
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_sel", 32'(sel), 32'(i));
      chk("fill_fv", 32'(frame_valid), 32'h0);
      in_data = words[i];
      push(i, words[i]);
      tick();
    end
    chk("frame1_fv", 32'(frame_valid), 32'h1);
    chk("frame1_sel", 32'(sel), 32'h0);
    chk("frame1_in_ready", 32'(in_ready), 32'h0);
    chk_lanes("frame1_lanes", 32'h44332211);

    // Stall for 10 cycles with data offered.
    in_data = 8'h99;
    for (int i = 0; i < 10; i++) tick();
    chk("stall_fv", 32'(frame_valid), 32'h1);
    chk("stall_strobe", 32'(lane_strobe), 32'h0);
    chk_lanes("stall_lanes", 32'h44332211);

    // Release with a same-cycle accept.
    frame_ready = 1'b1;
    in_data = 8'h55;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'h1);
    push(0, 8'h55);
    tick();
    frame_ready = 1'b0;
    chk("release_fv", 32'(frame_valid), 32'h0);
    chk("release_sel", 32'(sel), 32'h1);
    chk("release_strobe", 32'(lane_strobe), 32'h1);
    chk_lanes("release_lanes", 32'h44332255);

    for (int i = 1; i < 4; i++) begin
      in_data = 8'(8'h60 + i);
      push(i, 8'(8'h60 + i));
      tick();
    end
    chk_lanes("frame2_lanes", 32'h63626155);
    chk("frame2_fv", 32'(frame_valid), 32'h1);
    in_valid = 1'b0;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("consume2_fv", 32'(frame_valid), 32'h0);

    // Gapped input.
    fv_rises = 0;
    gap_pat[0] = 1; gap_pat[1] = 0; gap_pat[2] = 0; gap_pat[3] = 1;
    gap_pat[4] = 1; gap_pat[5] = 0; gap_pat[6] = 1;
    w = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = gap_pat[i];
      if (gap_pat[i]) begin
        in_data = 8'(8'hA0 + w);
        push(w, 8'(8'hA0 + w));
        w++;
      end else begin
        in_data = 8'hFF;
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("gap_fv", 32'(frame_valid), 32'h1);
    chk("gap_fv_rises", 32'(fv_rises), 32'h1);
    chk_lanes("gap_lanes", 32'hA3A2A1A0);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("consume3_fv", 32'(frame_valid), 32'h0);

    // Flush after two accepts.
    in_valid = 1'b1;
    in_data = 8'h01; push(0, 8'h01); tick();
    in_data = 8'h02; push(1, 8'h02); tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_sel", 32'(sel), 32'h0);
    chk("flush_fv", 32'(frame_valid), 32'h0);
    chk("flush_strobe", 32'(lane_strobe), 32'h0);
    chk_lanes("flush_lanes", 32'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h0A + i);
      push(i, 8'(8'h0A + i));
      tick();
    end
    in_valid = 1'b0;
    chk("frame4_fv", 32'(frame_valid), 32'h1);
    chk_lanes("frame4_lanes", 32'h0D0C0B0A);

    // Flush beats frame_ready and an accept in HOLD.
    flush = 1'b1; frame_ready = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    tick();
    flush = 1'b0; frame_ready = 1'b0; in_valid = 1'b0;
    chk("hflush_sel", 32'(sel), 32'h0);
    chk("hflush_strobe", 32'(lane_strobe), 32'h0);
    chk("hflush_fv", 32'(frame_valid), 32'h0);
    chk("hflush_in_ready", 32'(in_ready), 32'h1);
    chk_lanes("hflush_lanes", 32'h0);

    // Asynchronous reset mid-frame.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h21 + i);
      push(i, 8'(8'h21 + i));
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_sel", 32'(sel), 32'h0);
    chk("areset_strobe", 32'(lane_strobe), 32'h0);
    chk("areset_fv", 32'(frame_valid), 32'h0);
    chk_lanes("areset_lanes", 32'h0);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h31 + i);
      push(i, 8'(8'h31 + i));
      tick();
    end
    in_valid = 1'b0;
    chk("frame5_fv", 32'(frame_valid), 32'h1);
    chk_lanes("frame5_lanes", 32'h34333231);
    tick();

    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
